decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction-decode stage of the Kabeta pipeline. Sits directly upstream of RegisterFile and drives its read enables and read addresses.
- Holds one fetched instruction in an instruction register (IR) and decodes its fields.
- Interlocks read-after-write and write-after-write hazards with a per-register pending-write scoreboard.
- Hands decoded control, valid/ready-handshaked, to the execute stage.

Parameters:
W_DATA, 32, data/PC/literal width
W_ADDR, 5, register index width; index all-ones is zero register R31

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
InValid  input  1  fetch presents an instruction
InReady  output  1  stage accepts the instruction this cycle
InInstr  input  32  instruction word: [31:26] opcode, [25:21] Rc, [20:16] Ra, [15:11] Rb, [15:0] literal
InPC  input  W_DATA  PC+4 of InInstr
Flush  input  1  discard the held instruction (branch/trap redirect)
RfEnX, RfEnY  output  1  RegisterFile address-latch enables
RfAddrX, RfAddrY  output  W_ADDR  RegisterFile read addresses
OutValid  output  1  decoded instruction valid toward execute
OutReady  input  1  execute accepts
OutOpcode  output  6  IR opcode
OutRc  output  W_ADDR  destination/store-source index
OutLiteral  output  W_DATA  sign-extended IR[15:0]
OutPC  output  W_DATA  held PC+4
OutWrEn  output  1  instruction writes Rc (Rc != R31)
OutIllegal  output  1  opcode not in the legal set
WbEn  input  1  writeback writes the register file this cycle
WbAddr  input  W_ADDR  writeback index
StallCount  output  32  hazard-stall counter (optional feature)

Behaviour:
- Reset (async, Reset=0): IrValid=0, IR=0, held PC=0, scoreboard=0, StallCount=0. Outputs: OutValid=0, InReady=1, RfEn*=0.
- Opcode classes:
  - OP 10xxxx: reads Ra, Rb; writes Rc.
  - OPC 11xxxx: reads Ra; writes Rc.
  - LD 011000: reads Ra; writes Rc.
  - ST 011001: reads Ra, Rc; no write.
  - JMP 011011, BEQ 011100, BNE 011101: read Ra; write Rc.
  - LDR 011111: no reads; writes Rc.
  - All other opcodes: OutIllegal=1, no reads, no write.
- Hazard (combinational on IR): any read source index != R31 with its scoreboard bit set, or OutWrEn with bit[Rc] set.
- Handshakes:
  - OutValid = IrValid & !Hazard & !Flush.
  - FireOut = OutValid & OutReady.
  - InReady = !Flush & (!IrValid | FireOut).
  - Accept = InValid & InReady.
- Accept: IR and held PC load at the next edge; IrValid=1.
- FireOut without Accept: IrValid=0.
- Flush: IrValid=0 at the next edge; no Accept that cycle; scoreboard untouched, because in-flight writes still retire.
- RegisterFile drive (combinational from InInstr):
  - RfEnX = RfEnY = Accept.
  - RfAddrX = Ra.
  - RfAddrY = Rc if the opcode is ST, else Rb.
  - RegisterFile data therefore matches IR from the cycle after Accept. During a stall the addresses stay latched, so data reflects writebacks automatically.
- Scoreboard: register bits 0..30; bit 31 does not exist.
  - FireOut & OutWrEn sets bit[Rc].
  - WbEn & WbAddr != R31 clears bit[WbAddr].
  - Same-index set and clear in the same cycle: set wins.
  - Hazard uses the registered scoreboard only. A writeback costs exactly one bubble, matching the RegisterFile write timing.
- Latency: one cycle from Accept to OutValid when there is no hazard. Throughput is one instruction per cycle.
- Outputs are valid whenever OutValid=1. When OutValid=0, outputs reflect IR and are don't-care.

Optional Feature:
- Macro KABETA_DECODE_STALLCNT_EN.
- Defined: StallCount increments every cycle IrValid & Hazard & !Flush, and saturates at 0xFFFFFFFF. It is reset only by Reset.
- Undefined: no counter register; StallCount tied to 0.

Decomposition:
- Shared package kabeta_pkg holds:
  - opcode constants (OPC_LD, OPC_ST, OPC_JMP, OPC_BEQ, OPC_BNE, OPC_LDR);
  - class-prefix constants 2'b10/2'b11;
  - IDX_ZR;
  - instruction field bit positions.
- One sub-module, decode_ctrl: purely combinational opcode → {UsesRa, UsesRb, UsesRcRead, WritesRc, Illegal}, reused by execute.
- Scoreboard, IR and handshake stay in decode_stage.

Test Plan:
- Reset mid-operation: IrValid=1 with scoreboard bit 3 set, then Reset=0 → OutValid=0, InReady=1, scoreboard=0, StallCount=0.
- RAW stall:
  - Issue ADD r1,r2,r3 (OutReady=1), then SUB r4,r1,r5 → SUB OutValid=0 until WbEn=1 with WbAddr=1.
  - SUB OutValid=1 exactly one cycle after the writeback.
  - With the feature enabled, StallCount equals the number of stall cycles.
- ST reads Rc: InInstr ST with Rc=7, Ra=2 → RfAddrX=2, RfAddrY=7, RfEnX=RfEnY=1 in the Accept cycle; OutWrEn=0; no scoreboard set.
- Zero register: ADD r31,r31,r31 back-to-back ×4 → no stalls, OutWrEn=0, scoreboard stays 0.
- Backpressure and same-cycle set/clear:
  - OutReady=0 for 3 cycles → InReady=0, IR holds, RfEn*=0.
  - Then OutReady=1 and WbEn=1 with WbAddr=Rc of the firing instruction, same edge → scoreboard bit remains set.
- Flush: IrValid=1 with Flush=1 → InReady=0, OutValid=0; the next cycle IrValid=0. A pending scoreboard bit is cleared only by a later WbEn. Opcode 000000 → OutIllegal=1.

Source files
------------

// File: rtl/kabeta_pkg.sv
// Shared Kabeta ISA definitions: opcode constants, class prefixes, field positions
// and the decoded-control struct produced by decode_ctrl.
package kabeta_pkg;

  localparam int W_INSTR = 32;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RC_LO  = 21;
  localparam int RA_LO  = 16;
  localparam int RB_LO  = 11;
  localparam int LIT_HI = 15;
  localparam int LIT_LO = 0;

  localparam logic [5:0] OPC_LD  = 6'b011000;
  localparam logic [5:0] OPC_ST  = 6'b011001;
  localparam logic [5:0] OPC_JMP = 6'b011011;
  localparam logic [5:0] OPC_BEQ = 6'b011100;
  localparam logic [5:0] OPC_BNE = 6'b011101;
  localparam logic [5:0] OPC_LDR = 6'b011111;

  localparam logic [1:0] CLS_OP  = 2'b10;
  localparam logic [1:0] CLS_OPC = 2'b11;

  localparam logic [4:0] IDX_ZR = 5'd31;

  typedef struct packed {
    logic usesRa;
    logic usesRb;
    logic usesRcRead;
    logic writesRc;
    logic illegal;
  } decode_ctrl_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode classifier: which fields an instruction reads/writes and
// whether the opcode is legal. Shared with the execute stage.
module decode_ctrl
  import kabeta_pkg::*;
(
  input  logic [5:0]   Opcode,
  output decode_ctrl_t Ctrl
);

  always_comb begin
    Ctrl = '0;
    if (Opcode[5:4] == CLS_OP) begin
      Ctrl.usesRa   = 1'b1;
      Ctrl.usesRb   = 1'b1;
      Ctrl.writesRc = 1'b1;
    end else if (Opcode[5:4] == CLS_OPC) begin
      Ctrl.usesRa   = 1'b1;
      Ctrl.writesRc = 1'b1;
    end else begin
      case (Opcode)
        OPC_LD: begin
          Ctrl.usesRa   = 1'b1;
          Ctrl.writesRc = 1'b1;
        end
        OPC_ST: begin
          Ctrl.usesRa     = 1'b1;
          Ctrl.usesRcRead = 1'b1;
        end
        OPC_JMP, OPC_BEQ, OPC_BNE: begin
          Ctrl.usesRa   = 1'b1;
          Ctrl.writesRc = 1'b1;
        end
        OPC_LDR: Ctrl.writesRc = 1'b1;
        default: Ctrl.illegal  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Kabeta decode stage: instruction register, RAW/WAW scoreboard interlock and
// valid/ready handoff to execute. Define KABETA_DECODE_STALLCNT_EN for StallCount.
module decode_stage
  import kabeta_pkg::*;
#(
  parameter int W_DATA = 32,
  parameter int W_ADDR = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       InInstr,
  input  logic [W_DATA-1:0] InPC,
  input  logic              Flush,
  output logic              RfEnX,
  output logic              RfEnY,
  output logic [W_ADDR-1:0] RfAddrX,
  output logic [W_ADDR-1:0] RfAddrY,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [5:0]        OutOpcode,
  output logic [W_ADDR-1:0] OutRc,
  output logic [W_DATA-1:0] OutLiteral,
  output logic [W_DATA-1:0] OutPC,
  output logic              OutWrEn,
  output logic              OutIllegal,
  input  logic              WbEn,
  input  logic [W_ADDR-1:0] WbAddr,
  output logic [31:0]       StallCount
);

  localparam int NREG = 2 ** W_ADDR;
  localparam logic [W_ADDR-1:0] ZR = '1;

  logic [W_INSTR-1:0] ir;
  logic [W_DATA-1:0]  pcHeld;
  logic               irValid;
  logic [NREG-2:0]    scoreboard;
  logic [NREG-2:0]    sbNext;
  logic [NREG-1:0]    sbView;
  decode_ctrl_t       ctrl;
  logic [W_ADDR-1:0]  irRc, irRa, irRb;
  logic               hazard, fireOut, accept;

  assign irRc = ir[RC_LO +: W_ADDR];
  assign irRa = ir[RA_LO +: W_ADDR];
  assign irRb = ir[RB_LO +: W_ADDR];

  decode_ctrl uCtrl (
    .Opcode (ir[OP_HI:OP_LO]),
    .Ctrl   (ctrl)
  );

  // R31 has no scoreboard bit; the padded top bit makes its lookup read 0.
  assign sbView = {1'b0, scoreboard};

  assign OutWrEn = ctrl.writesRc & (irRc != ZR);
  assign hazard  = (ctrl.usesRa     & sbView[irRa])
                 | (ctrl.usesRb     & sbView[irRb])
                 | (ctrl.usesRcRead & sbView[irRc])
                 | (OutWrEn         & sbView[irRc]);

  assign OutValid = irValid & ~hazard & ~Flush;
  assign fireOut  = OutValid & OutReady;
  assign InReady  = ~Flush & (~irValid | fireOut);
  assign accept   = InValid & InReady;

  // Register-file addresses come straight from the incoming word so read data
  // lines up with IR on the cycle after accept.
  assign RfEnX   = accept;
  assign RfEnY   = accept;
  assign RfAddrX = InInstr[RA_LO +: W_ADDR];
  assign RfAddrY = (InInstr[OP_HI:OP_LO] == OPC_ST) ? InInstr[RC_LO +: W_ADDR]
                                                     : InInstr[RB_LO +: W_ADDR];

  assign OutOpcode  = ir[OP_HI:OP_LO];
  assign OutRc      = irRc;
  assign OutLiteral = {{(W_DATA-16){ir[LIT_HI]}}, ir[LIT_HI:LIT_LO]};
  assign OutPC      = pcHeld;
  assign OutIllegal = ctrl.illegal;

  // Clear first, then set, so an issuing write beats a same-cycle retirement.
  always_comb begin
    sbNext = scoreboard;
    for (int i = 0; i < NREG - 1; i++) begin
      if (WbEn && WbAddr == W_ADDR'(i))
        sbNext[i] = 1'b0;
      if (fireOut && OutWrEn && irRc == W_ADDR'(i))
        sbNext[i] = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      irValid    <= 1'b0;
      ir         <= '0;
      pcHeld     <= '0;
      scoreboard <= '0;
    end else begin
      scoreboard <= sbNext;
      if (accept) begin
        irValid <= 1'b1;
        ir      <= InInstr;
        pcHeld  <= InPC;
      end else if (fireOut || Flush) begin
        irValid <= 1'b0;
      end
    end
  end

`ifdef KABETA_DECODE_STALLCNT_EN
  logic [31:0] stallCnt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      stallCnt <= '0;
    else if (irValid && hazard && !Flush && stallCnt != 32'hFFFF_FFFF)
      stallCnt <= stallCnt + 32'd1;
  end

  assign StallCount = stallCnt;
`else
  assign StallCount = '0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; inputs driven and outputs
// sampled around the falling clock edge.
module tb_decode_stage;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InValid, InReady, Flush;
  logic [31:0] InInstr, InPC;
  logic        RfEnX, RfEnY;
  logic [4:0]  RfAddrX, RfAddrY;
  logic        OutValid, OutReady;
  logic [5:0]  OutOpcode;
  logic [4:0]  OutRc;
  logic [31:0] OutLiteral, OutPC;
  logic        OutWrEn, OutIllegal, WbEn;
  logic [4:0]  WbAddr;
  logic [31:0] StallCount;

  int checks = 0;
  int errors = 0;

  decode_stage #(.W_DATA(32), .W_ADDR(5)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InInstr(InInstr), .InPC(InPC), .Flush(Flush), .RfEnX(RfEnX), .RfEnY(RfEnY),
    .RfAddrX(RfAddrX), .RfAddrY(RfAddrY), .OutValid(OutValid), .OutReady(OutReady),
    .OutOpcode(OutOpcode), .OutRc(OutRc), .OutLiteral(OutLiteral), .OutPC(OutPC),
    .OutWrEn(OutWrEn), .OutIllegal(OutIllegal), .WbEn(WbEn), .WbAddr(WbAddr),
    .StallCount(StallCount)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rc,
                                      input logic [4:0] ra, input logic [4:0] rb);
    return {op, rc, ra, rb, 11'b0};
  endfunction

  function automatic logic [31:0] encL(input logic [5:0] op, input logic [4:0] rc,
                                       input logic [4:0] ra, input logic [15:0] lit);
    return {op, rc, ra, lit};
  endfunction

  task automatic idle();
    InValid = 0; OutReady = 0; Flush = 0; WbEn = 0; WbAddr = 0;
  endtask

  task automatic nxt();
    @(negedge Clock);
  endtask

  task automatic test_reset();
    Reset = 0; idle(); InInstr = 0; InPC = 0;
    #2;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got %b exp 0", OutValid); end
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_inready got %b exp 1", InReady); end
    checks++; if (RfEnX !== 1'b0 || RfEnY !== 1'b0) begin errors++; $display("FAIL reset_rfen got %b%b exp 00", RfEnX, RfEnY); end
    checks++; if (StallCount !== 32'd0) begin errors++; $display("FAIL reset_stallcnt got %0d exp 0", StallCount); end
    checks++; if (OutPC !== 32'd0 || OutOpcode !== 6'd0) begin errors++; $display("FAIL reset_ir pc=%h op=%h exp 0", OutPC, OutOpcode); end
    nxt(); Reset = 1;
  endtask

  task automatic test_raw_stall();
    int stalls;
    nxt(); InValid = 1; InInstr = enc(6'b100000, 5'd1, 5'd2, 5'd3); InPC = 32'h100; OutReady = 1;
    #1;
    checks++; if (RfEnX !== 1'b1 || RfAddrX !== 5'd2 || RfAddrY !== 5'd3) begin errors++; $display("FAIL raw_add_rf en=%b x=%0d y=%0d exp 1 2 3", RfEnX, RfAddrX, RfAddrY); end
    nxt(); InInstr = enc(6'b100001, 5'd4, 5'd1, 5'd5); InPC = 32'h104;
    #1;
    checks++; if (OutValid !== 1'b1 || OutRc !== 5'd1 || OutPC !== 32'h100 || OutWrEn !== 1'b1) begin errors++; $display("FAIL raw_add_out v=%b rc=%0d pc=%h we=%b exp 1 1 100 1", OutValid, OutRc, OutPC, OutWrEn); end
    checks++; if (OutLiteral !== 32'h0000_1800) begin errors++; $display("FAIL raw_add_lit got %h exp 00001800", OutLiteral); end
    stalls = 0;
    nxt(); InValid = 0;
    #1;
    checks++; if (OutValid !== 1'b0 || OutRc !== 5'd4) begin errors++; $display("FAIL raw_stall1 v=%b rc=%0d exp 0 4", OutValid, OutRc); end
    stalls++;
    nxt(); WbEn = 1; WbAddr = 5'd1;
    #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL raw_stall_wb v=%b exp 0", OutValid); end
    stalls++;
    nxt(); WbEn = 0;
    #1;
    checks++; if (OutValid !== 1'b1 || OutPC !== 32'h104) begin errors++; $display("FAIL raw_release v=%b pc=%h exp 1 104", OutValid, OutPC); end
`ifdef KABETA_DECODE_STALLCNT_EN
    checks++; if (StallCount !== 32'(stalls)) begin errors++; $display("FAIL raw_stallcnt got %0d exp %0d", StallCount, stalls); end
`else
    checks++; if (StallCount !== 32'd0) begin errors++; $display("FAIL raw_stallcnt got %0d exp 0 (stalls %0d)", StallCount, stalls); end
`endif
    // SUB fired on this edge and set r4; retire it.
    nxt(); OutReady = 0; WbEn = 1; WbAddr = 5'd4;
    #1;
    checks++; if (OutValid !== 1'b0 || InReady !== 1'b1) begin errors++; $display("FAIL raw_drain v=%b rdy=%b exp 0 1", OutValid, InReady); end
    nxt(); idle();
  endtask

  task automatic test_store();
    nxt(); InValid = 1; InInstr = enc(6'b011001, 5'd7, 5'd2, 5'd9); OutReady = 1;
    #1;
    checks++; if (RfEnX !== 1'b1 || RfEnY !== 1'b1 || RfAddrX !== 5'd2 || RfAddrY !== 5'd7) begin errors++; $display("FAIL st_rf en=%b%b x=%0d y=%0d exp 11 2 7", RfEnX, RfEnY, RfAddrX, RfAddrY); end
    nxt(); InInstr = enc(6'b100000, 5'd31, 5'd7, 5'd7);
    #1;
    checks++; if (OutValid !== 1'b1 || OutWrEn !== 1'b0 || OutIllegal !== 1'b0) begin errors++; $display("FAIL st_out v=%b we=%b ill=%b exp 1 0 0", OutValid, OutWrEn, OutIllegal); end
    nxt(); InValid = 0;
    #1;
    checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL st_no_sb reader of r7 v=%b exp 1", OutValid); end
    nxt(); idle();
  endtask

  task automatic test_zero_reg();
    nxt(); InValid = 1; OutReady = 1; InInstr = enc(6'b100000, 5'd31, 5'd31, 5'd31);
    for (int i = 0; i < 4; i++) begin
      nxt();
      if (i == 3) InValid = 0;
      #1;
      checks++; if (OutValid !== 1'b1 || OutWrEn !== 1'b0 || InReady !== 1'b1) begin errors++; $display("FAIL zr_b2b%0d v=%b we=%b rdy=%b exp 1 0 1", i, OutValid, OutWrEn, InReady); end
    end
    nxt();
    #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL zr_drain v=%b exp 0", OutValid); end
    // No scoreboard bit may have been set: a r31-destination ADD then an r31 reader issue freely.
    nxt(); idle();
  endtask

  task automatic test_backpressure();
    nxt(); InValid = 1; InInstr = enc(6'b100000, 5'd9, 5'd1, 5'd2); InPC = 32'h200;
    nxt(); InInstr = enc(6'b100000, 5'd10, 5'd3, 5'd4); InPC = 32'h204; OutReady = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (OutValid !== 1'b1 || InReady !== 1'b0 || RfEnX !== 1'b0 || RfEnY !== 1'b0 || OutRc !== 5'd9 || OutPC !== 32'h200) begin
        errors++; $display("FAIL bp_hold%0d v=%b rdy=%b en=%b%b rc=%0d pc=%h exp 1 0 00 9 200", i, OutValid, InReady, RfEnX, RfEnY, OutRc, OutPC); end
      nxt();
    end
    InValid = 0; OutReady = 1; WbEn = 1; WbAddr = 5'd9;
    nxt(); WbEn = 0; OutReady = 0; InValid = 1; InInstr = enc(6'b110000, 5'd31, 5'd9, 5'd0);
    nxt(); InValid = 0;
    #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL bp_set_wins reader of r9 v=%b exp 0", OutValid); end
    WbEn = 1; WbAddr = 5'd9;
    nxt(); WbEn = 0; OutReady = 1;
    #1;
    checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL bp_release v=%b exp 1", OutValid); end
    nxt(); idle();
  endtask

  task automatic test_flush();
    nxt(); InValid = 1; OutReady = 1; InInstr = enc(6'b100000, 5'd13, 5'd31, 5'd31);
    nxt(); InInstr = encL(6'b110000, 5'd31, 5'd13, 16'h0);
    nxt(); Flush = 1; InInstr = enc(6'b100000, 5'd31, 5'd31, 5'd31);
    #1;
    checks++; if (InReady !== 1'b0 || OutValid !== 1'b0 || RfEnX !== 1'b0) begin errors++; $display("FAIL fl_active rdy=%b v=%b en=%b exp 0 0 0", InReady, OutValid, RfEnX); end
    nxt(); Flush = 0; InValid = 0;
    #1;
    checks++; if (OutValid !== 1'b0 || InReady !== 1'b1) begin errors++; $display("FAIL fl_empty v=%b rdy=%b exp 0 1", OutValid, InReady); end
    InValid = 1; InInstr = encL(6'b110000, 5'd31, 5'd13, 16'h0);
    nxt(); InValid = 0;
    #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL fl_sb_kept v=%b exp 0", OutValid); end
    WbEn = 1; WbAddr = 5'd13;
    nxt(); WbEn = 0; InValid = 1; InInstr = enc(6'b000000, 5'd3, 5'd4, 5'd5);
    #1;
    checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL fl_wb_release v=%b exp 1", OutValid); end
    nxt(); InInstr = encL(6'b011111, 5'd31, 5'd0, 16'h8004); InPC = 32'h300;
    #1;
    checks++; if (OutValid !== 1'b1 || OutIllegal !== 1'b1 || OutWrEn !== 1'b0) begin errors++; $display("FAIL illegal v=%b ill=%b we=%b exp 1 1 0", OutValid, OutIllegal, OutWrEn); end
    nxt(); InValid = 0;
    #1;
    checks++; if (OutLiteral !== 32'hFFFF_8004 || OutIllegal !== 1'b0 || OutWrEn !== 1'b0 || OutPC !== 32'h300) begin errors++; $display("FAIL ldr_sext lit=%h ill=%b we=%b pc=%h exp ffff8004 0 0 300", OutLiteral, OutIllegal, OutWrEn, OutPC); end
    nxt(); idle();
  endtask

  task automatic test_reset_mid();
    nxt(); InValid = 1; OutReady = 1; InInstr = enc(6'b100000, 5'd3, 5'd31, 5'd31);
    nxt(); InInstr = enc(6'b100000, 5'd6, 5'd3, 5'd31);
    nxt(); InValid = 0;
    nxt();
    #1;
    checks++; if (OutValid !== 1'b0 || InReady !== 1'b0) begin errors++; $display("FAIL rm_pre v=%b rdy=%b exp 0 0", OutValid, InReady); end
    Reset = 0;
    #1;
    checks++; if (OutValid !== 1'b0 || InReady !== 1'b1 || StallCount !== 32'd0) begin errors++; $display("FAIL rm_reset v=%b rdy=%b cnt=%0d exp 0 1 0", OutValid, InReady, StallCount); end
    nxt(); Reset = 1; InValid = 1; InInstr = enc(6'b100000, 5'd31, 5'd3, 5'd31);
    nxt(); InValid = 0;
    #1;
    checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL rm_sb_cleared reader of r3 v=%b exp 1", OutValid); end
    nxt(); idle();
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_store();
    test_zero_reg();
    test_backpressure();
    test_flush();
    test_reset_mid();
    repeat (2) nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
